configs_loader: RTL and testbench

CONFIGS_LOADER -- requirements
Module: configs_loader

---
 rtl/configs_pkg.sv | 20 ++
 rtl/configs_shadow_bank.sv | 46 ++++
 rtl/configs_loader.sv | 166 ++++++++++++++++
 tb/tb_configs_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/configs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : configs_pkg
// Description : Shared types and default sizing for the configuration loader
//               (FSM state encoding, default word width and word count).
// Revision    : 1.0 - initial release
// ============================================================================
package configs_pkg;

  localparam int CFG_DATA_W_DEFAULT    = 32;
  localparam int CFG_NUM_WORDS_DEFAULT = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    LOAD   = 2'd2
  } state_t;

endpackage : configs_pkg
`default_nettype wire

// File: rtl/configs_shadow_bank.sv
`default_nettype none
// ============================================================================
// Module      : configs_shadow_bank
// Description : Staging storage for a configuration load. One register per
//               word with its own write enable; all words exposed flat.
// Revision    : 1.0 - initial release
// ============================================================================
module configs_shadow_bank
  import configs_pkg::*;
#(
  parameter int DATA_W    = CFG_DATA_W_DEFAULT,
  parameter int NUM_WORDS = CFG_NUM_WORDS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WORDS-1:0]        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic [DATA_W*NUM_WORDS-1:0] words
);

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;

    // Capture the incoming payload only when this word is addressed.
    always_comb begin
      word_d = word_q;
      if (wr_en[k]) begin
        word_d = wr_data;
      end
    end

    // Word register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign words[k*DATA_W +: DATA_W] = word_q;
  end

endmodule : configs_shadow_bank
`default_nettype wire

// File: rtl/configs_loader.sv
`default_nettype none
// ============================================================================
// Module      : configs_loader
// Description : Loads NUM_WORDS configuration words through a valid/ready
//               stream into a shadow bank, then publishes them atomically.
//               Optional macro CONFIGS_LOADER_READBACK_EN adds a registered
//               read port (io_rd_addr / io_rd_data) on the committed words.
// Revision    : 1.0 - initial release
// ============================================================================
module configs_loader
  import configs_pkg::*;
#(
  parameter  int DATA_W    = CFG_DATA_W_DEFAULT,
  parameter  int NUM_WORDS = CFG_NUM_WORDS_DEFAULT,
  localparam int PTR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_start,
  input  logic [DATA_W-1:0]           io_d_in,
  input  logic                        io_d_valid,
  output logic                        io_d_ready,
  output logic                        io_busy,
  output logic                        io_done,
  output logic [DATA_W*NUM_WORDS-1:0] io_configs_out
`ifdef CONFIGS_LOADER_READBACK_EN
  ,
  input  logic [PTR_W-1:0]            io_rd_addr,
  output logic [DATA_W-1:0]           io_rd_data
`endif
);

  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(NUM_WORDS - 1);

  state_t                        state_q, state_d;
  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [DATA_W*NUM_WORDS-1:0]   configs_q, configs_d;

  logic                          w_xfer;
  logic                          w_last_xfer;
  logic [NUM_WORDS-1:0]          w_wr_en;
  logic [DATA_W*NUM_WORDS-1:0]   w_shadow_words;
  logic [DATA_W*NUM_WORDS-1:0]   w_commit_words;

  // Control FSM: next state, pointer and handshake/status outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    w_xfer      = 1'b0;
    w_last_xfer = 1'b0;
    io_d_ready  = 1'b0;
    io_busy     = 1'b0;
    io_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        io_d_ready = 1'b1;
        io_busy    = 1'b1;
        if (io_start) begin
          // Restart wins over a coincident transfer; shadow keeps old data.
          ptr_d = '0;
        end else if (io_d_valid) begin
          w_xfer = 1'b1;
          if (ptr_q == C_LAST_PTR) begin
            w_last_xfer = 1'b1;
            state_d     = COMMIT;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      COMMIT: begin
        io_busy = 1'b1;
        io_done = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One write enable per shadow word, selected by the pointer.
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_wr_en
    assign w_wr_en[k] = w_xfer && (ptr_q == PTR_W'(k));
  end

  configs_shadow_bank #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_data (io_d_in),
    .words   (w_shadow_words)
  );

  // The final word is still on io_d_in when the load completes, so it is
  // merged here; the whole set lands in one edge and io_configs_out is
  // already new during the cycle io_done is high.
  always_comb begin
    w_commit_words = w_shadow_words;
    w_commit_words[(NUM_WORDS-1)*DATA_W +: DATA_W] = io_d_in;
  end

  // Published configuration only moves when a complete load commits.
  always_comb begin
    configs_d = configs_q;
    if (w_last_xfer) begin
      configs_d = w_commit_words;
    end
  end

  // State, pointer and committed configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      configs_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      configs_q <= configs_d;
    end
  end

  assign io_configs_out = configs_q;

`ifdef CONFIGS_LOADER_READBACK_EN
  localparam logic [PTR_W:0] C_NUM_WORDS = (PTR_W+1)'(NUM_WORDS);

  logic [DATA_W-1:0] w_cfg_words [NUM_WORDS];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_rd_word
    assign w_cfg_words[k] = configs_q[k*DATA_W +: DATA_W];
  end

  // Select the committed word; addresses past the last word read as zero.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, io_rd_addr} < C_NUM_WORDS) begin
      rd_data_d = w_cfg_words[io_rd_addr];
    end
  end

  // Read data register giving one cycle of latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign io_rd_data = rd_data_q;
`endif

endmodule : configs_loader
`default_nettype wire

// File: tb/tb_configs_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_configs_loader
// Description : Self-checking bench for configs_loader. Stimulus words and
//               valid patterns are randomized; expected outputs come from a
//               word-array model of the last complete load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_configs_loader;

  localparam int DW = 32;
  localparam int NW = 23;

  logic               clk;
  logic               reset;
  logic               io_start;
  logic [DW-1:0]      io_d_in;
  logic               io_d_valid;
  logic               io_d_ready;
  logic               io_busy;
  logic               io_done;
  logic [DW*NW-1:0]   io_configs_out;
`ifdef CONFIGS_LOADER_READBACK_EN
  logic [4:0]         io_rd_addr;
  logic [DW-1:0]      io_rd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] stim      [NW];
  logic [DW-1:0] model_cfg [NW];

  configs_loader #(
    .DATA_W    (DW),
    .NUM_WORDS (NW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_start       (io_start),
    .io_d_in        (io_d_in),
    .io_d_valid     (io_d_valid),
    .io_d_ready     (io_d_ready),
    .io_busy        (io_busy),
    .io_done        (io_done),
    .io_configs_out (io_configs_out)
`ifdef CONFIGS_LOADER_READBACK_EN
    ,
    .io_rd_addr     (io_rd_addr),
    .io_rd_data     (io_rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*NW-1:0] pack_model();
    logic [DW*NW-1:0] r;
    for (int k = 0; k < NW; k++) r[k*DW +: DW] = model_cfg[k];
    return r;
  endfunction

  // Full load from stim[]; vmode 0 = valid held, 1 = toggling, 2 = random.
  task automatic run_load(input bit do_start, input int vmode, input bit start_in_commit);
    int acc = 0;
    int cyc = 0;
    int rnd;
    bit v;
    if (do_start) begin
      io_start = 1'b1;
      step();
      io_start = 1'b0;
    end
    while (acc < NW && cyc < 1000) begin
      rnd = $urandom_range(0, 1);
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : rnd[0];
      io_d_valid = v;
      io_d_in    = stim[acc];
      n_tests++;
      if (io_done !== 1'b0 || io_busy !== 1'b1 || io_d_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ctrl: done=%b busy=%b ready=%b, required done=0 busy=1 ready=1 (word %0d)",
                 io_done, io_busy, io_d_ready, acc);
      end
      n_tests++;
      if (io_configs_out !== pack_model()) begin
        n_fail++;
        $display("FAIL load_hold: configs_out=%h required=%h", io_configs_out, pack_model());
      end
      if (v) acc++;
      cyc++;
      step();
    end
    io_d_valid = 1'b0;
    n_tests++;
    if (acc < NW) begin
      n_fail++;
      $display("FAIL load_timeout: accepted=%0d required=%0d", acc, NW);
    end
    if (vmode == 0) begin
      n_tests++;
      if (cyc != NW) begin
        n_fail++;
        $display("FAIL ready_cycles: ready cycles=%0d required=%0d", cyc, NW);
      end
    end
    for (int k = 0; k < NW; k++) model_cfg[k] = stim[k];
    n_tests++;
    if (io_done !== 1'b1 || io_busy !== 1'b1 || io_d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_ctrl: done=%b busy=%b ready=%b, required done=1 busy=1 ready=0",
               io_done, io_busy, io_d_ready);
    end
    n_tests++;
    if (io_configs_out !== pack_model()) begin
      n_fail++;
      $display("FAIL commit_data: configs_out=%h required=%h", io_configs_out, pack_model());
    end
    if (start_in_commit) io_start = 1'b1;
    step();
    io_start = 1'b0;
    n_tests++;
    if (io_done !== 1'b0 || io_busy !== 1'b0 || io_d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_commit: done=%b busy=%b ready=%b, required all 0",
               io_done, io_busy, io_d_ready);
    end
    n_tests++;
    if (io_configs_out !== pack_model()) begin
      n_fail++;
      $display("FAIL post_commit_data: configs_out=%h required=%h", io_configs_out, pack_model());
    end
  endtask

  // Start a load and deliver n words with valid held high (no commit).
  task automatic partial_load(input int n);
    io_start = 1'b1;
    step();
    io_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      io_d_valid = 1'b1;
      io_d_in    = stim[i];
      step();
    end
    io_d_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    step();
    n_tests++;
    if (io_done !== 1'b0 || io_busy !== 1'b0 || io_d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: done=%b busy=%b ready=%b, required all 0", io_done, io_busy, io_d_ready);
    end
    n_tests++;
    if (io_configs_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: configs_out=%h required 0", io_configs_out);
    end
`ifdef CONFIGS_LOADER_READBACK_EN
    n_tests++;
    if (io_rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rd: rd_data=%h required 0", io_rd_data);
    end
`endif
    reset = 1'b1;
    step();
    for (int k = 0; k < NW; k++) model_cfg[k] = '0;
  endtask

  task automatic test_full_load();
    for (int k = 0; k < NW; k++) stim[k] = 32'h1000 + k;
    run_load(1'b1, 0, 1'b0);
    n_tests++;
    if (io_configs_out[22*DW +: DW] !== 32'h0000_1016) begin
      n_fail++;
      $display("FAIL full_load_word22: got=%h required=00001016", io_configs_out[22*DW +: DW]);
    end
  endtask

  task automatic test_toggle_valid();
    for (int k = 0; k < NW; k++) stim[k] = $urandom;
    run_load(1'b1, 1, 1'b0);
  endtask

  task automatic test_restart();
    for (int k = 0; k < NW; k++) stim[k] = 32'hA5A5_A5A5;
    run_load(1'b1, 0, 1'b0);
    for (int k = 0; k < NW; k++) stim[k] = 32'h5;
    partial_load(10);
    io_start   = 1'b1;
    io_d_valid = 1'b1;
    io_d_in    = 32'hDEAD_BEEF;
    n_tests++;
    if (io_configs_out !== pack_model()) begin
      n_fail++;
      $display("FAIL restart_hold: configs_out=%h required=%h", io_configs_out, pack_model());
    end
    step();
    io_start   = 1'b0;
    io_d_valid = 1'b0;
    for (int k = 0; k < NW; k++) stim[k] = 32'h7;
    run_load(1'b0, 0, 1'b0);
  endtask

  task automatic test_random_restart();
    int cut;
    cut = $urandom_range(1, NW - 1);
    for (int k = 0; k < NW; k++) stim[k] = $urandom;
    partial_load(cut);
    io_start = 1'b1;
    step();
    io_start = 1'b0;
    for (int k = 0; k < NW; k++) stim[k] = $urandom;
    run_load(1'b0, 2, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < NW; k++) stim[k] = $urandom;
    partial_load(12);
    #3;
    reset = 1'b0;
    #1;
    for (int k = 0; k < NW; k++) model_cfg[k] = '0;
    n_tests++;
    if (io_done !== 1'b0 || io_busy !== 1'b0 || io_d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ctrl: done=%b busy=%b ready=%b, required all 0", io_done, io_busy, io_d_ready);
    end
    n_tests++;
    if (io_configs_out !== '0) begin
      n_fail++;
      $display("FAIL midreset_data: configs_out=%h required 0", io_configs_out);
    end
    step();
    reset = 1'b1;
    step();
    n_tests++;
    if (io_done !== 1'b0 || io_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: done=%b busy=%b, required 0/0", io_done, io_busy);
    end
    for (int k = 0; k < NW; k++) stim[k] = $urandom;
    run_load(1'b1, 2, 1'b0);
  endtask

  task automatic test_idle_valid();
    for (int i = 0; i < 5; i++) begin
      io_d_valid = 1'b1;
      io_d_in    = $urandom;
      n_tests++;
      if (io_d_ready !== 1'b0 || io_busy !== 1'b0 || io_done !== 1'b0 ||
          io_configs_out !== pack_model()) begin
        n_fail++;
        $display("FAIL idle_valid: ready=%b busy=%b done=%b configs_out=%h required idle and %h",
                 io_d_ready, io_busy, io_done, io_configs_out, pack_model());
      end
      step();
    end
    io_d_valid = 1'b0;
    for (int k = 0; k < NW; k++) stim[k] = $urandom;
    run_load(1'b1, 2, 1'b1);
    step();
    n_tests++;
    if (io_busy !== 1'b0 || io_d_ready !== 1'b0 || io_done !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_start_ignored: busy=%b ready=%b done=%b, required all 0",
               io_busy, io_d_ready, io_done);
    end
  endtask

`ifdef CONFIGS_LOADER_READBACK_EN
  task automatic test_readback();
    logic [4:0]    a;
    logic [DW-1:0] exp;
    for (int k = 0; k < NW; k++) stim[k] = 32'h1000 + k;
    run_load(1'b1, 0, 1'b0);
    io_rd_addr = 5'd22;
    step();
    n_tests++;
    if (io_rd_data !== 32'h0000_1016) begin
      n_fail++;
      $display("FAIL rd_addr22: rd_data=%h required=00001016", io_rd_data);
    end
    io_rd_addr = 5'd31;
    step();
    n_tests++;
    if (io_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_addr31: rd_data=%h required=0", io_rd_data);
    end
    for (int i = 0; i < 8; i++) begin
      a = 5'($urandom_range(0, 31));
      io_rd_addr = a;
      exp = (int'(a) < NW) ? model_cfg[a] : '0;
      step();
      n_tests++;
      if (io_rd_data !== exp) begin
        n_fail++;
        $display("FAIL rd_random: addr=%0d rd_data=%h required=%h", a, io_rd_data, exp);
      end
    end
  endtask
`endif

  initial begin
    io_start   = 1'b0;
    io_d_in    = '0;
    io_d_valid = 1'b0;
`ifdef CONFIGS_LOADER_READBACK_EN
    io_rd_addr = '0;
`endif
    for (int k = 0; k < NW; k++) model_cfg[k] = '0;
    test_reset();
    test_full_load();
    test_toggle_valid();
    test_restart();
    test_random_restart();
    test_reset_mid_load();
    test_idle_valid();
`ifdef CONFIGS_LOADER_READBACK_EN
    test_readback();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_configs_loader
`default_nettype wire
